// File: rtl/dac_frame_rx.sv
// Receive side of the 12x8-lane DAC serial link: deframes 96 SYNC-framed lanes
// back into the 768-bit DAC value word and flags power-down bits and framing errors.
module dac_frame_rx #(
  parameter int unsigned PAD_BITS   = 6,
  parameter bit          STRICT_PAD = 1'b1
) (
  input  logic         SCLK,
  input  logic         RESET_N,
  input  logic         ACTIVE_N,
  input  logic         SYNC,
  input  logic [0:7]   SDIN1,
  input  logic [0:7]   SDIN2,
  input  logic [0:7]   SDIN3,
  input  logic [0:7]   SDIN4,
  input  logic [0:7]   SDIN5,
  input  logic [0:7]   SDIN6,
  input  logic [0:7]   SDIN7,
  input  logic [0:7]   SDIN8,
  input  logic [0:7]   SDIN9,
  input  logic [0:7]   SDIN10,
  input  logic [0:7]   SDIN11,
  input  logic [0:7]   SDIN12,
  output logic [0:767] nmbr_out,
  output logic         valid,
  output logic         pd_nz,
  output logic         frame_err
);

  localparam int unsigned PORTS     = 12;
  localparam int unsigned ROWS      = 8;
  localparam int unsigned LANES     = PORTS * ROWS;
  localparam int unsigned WORD_W    = LANES * 8;
  localparam int unsigned FRAME_LEN = 10 + PAD_BITS;
  localparam int unsigned SHR_W     = FRAME_LEN - 1;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    DISARM    = 2'd0,
    ARMED     = 2'd1,
    SHIFT     = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SHR_W-1:0][LANES-1:0]  planes_q;
  logic [0:WORD_W-1]            nmbr_q;
  logic                         valid_q, pd_nz_q, frame_err_q;

  logic [0:7]                   sdin_c [PORTS];
  logic [LANES-1:0]             lane_c;
  logic [FRAME_LEN-1:0][LANES-1:0] frame_c;
  logic [0:WORD_W-1]            word_c;
  logic                         pd_c, pad_nz_c;
  logic                         shift_en_c, accept_c, reject_c;

  assign sdin_c[0]  = SDIN1;
  assign sdin_c[1]  = SDIN2;
  assign sdin_c[2]  = SDIN3;
  assign sdin_c[3]  = SDIN4;
  assign sdin_c[4]  = SDIN5;
  assign sdin_c[5]  = SDIN6;
  assign sdin_c[6]  = SDIN7;
  assign sdin_c[7]  = SDIN8;
  assign sdin_c[8]  = SDIN9;
  assign sdin_c[9]  = SDIN10;
  assign sdin_c[10] = SDIN11;
  assign sdin_c[11] = SDIN12;

  // Lane n = row*12 + port, so lane n owns word bits n*8 .. n*8+7.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gk = 0; gk < PORTS; gk++) begin : g_port
      assign lane_c[gi*PORTS + gk] = sdin_c[gk][gi];
    end
  end

  // Whole frame as bit planes: serial bit t of every lane is frame_c[FRAME_LEN-1-t].
  assign frame_c = {planes_q, lane_c};

  for (genvar gn = 0; gn < LANES; gn++) begin : g_lane
    for (genvar gb = 0; gb < 8; gb++) begin : g_bit
      assign word_c[gn*8 + gb] = frame_c[FRAME_LEN-3-gb][gn];
    end
  end

  assign pd_c     = (|frame_c[FRAME_LEN-1]) | (|frame_c[FRAME_LEN-2]);
  assign pad_nz_c = |(frame_c[PAD_BITS-1:0]);

  // Framing state machine: next state and per-edge strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en_c = 1'b0;
    accept_c   = 1'b0;
    reject_c   = 1'b0;
    case (state_q)
      DISARM: begin
        if (SYNC) state_d = ARMED;
      end
      ARMED: begin
        if (!SYNC) begin
          shift_en_c = 1'b1;
          cnt_d      = CNT_W'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (SYNC) begin
          // Early rise doubles as the high phase that arms the next frame.
          reject_c = 1'b1;
          cnt_d    = '0;
          state_d  = ARMED;
        end else begin
          shift_en_c = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = WAIT_HIGH;
            if (STRICT_PAD && pad_nz_c) reject_c = 1'b1;
            else                        accept_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (SYNC) begin
          state_d = ARMED;
        end else begin
          reject_c = 1'b1;
          state_d  = DISARM;
        end
      end
      default: state_d = DISARM;
    endcase
  end

  // ACTIVE_N gates every register, reset included.
  always_ff @(posedge SCLK) begin
    if (ACTIVE_N) begin
      if (!RESET_N) begin
        state_q     <= DISARM;
        cnt_q       <= '0;
        planes_q    <= '0;
        nmbr_q      <= '0;
        valid_q     <= 1'b0;
        pd_nz_q     <= 1'b0;
        frame_err_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        valid_q     <= accept_c;
        frame_err_q <= reject_c;
        if (shift_en_c) planes_q <= {planes_q[SHR_W-2:0], lane_c};
        if (accept_c) begin
          nmbr_q  <= word_c;
          pd_nz_q <= pd_c;
        end
      end
    end
  end

  assign nmbr_out  = nmbr_q;
  assign valid     = valid_q;
  assign pd_nz     = pd_nz_q;
  assign frame_err = frame_err_q;

endmodule
